// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Purpose:
//   Pipeline hazard controller. It produces the stage enables and flushes for
//   the PC, IF/ID, ID/EX, EX/MEM and MEM/WB latches. It resolves load-use
//   stalls, taken jump/branch flushes, data-memory wait stalls and halt.
//
// Ports:
//   CLK, RST              clock, asynchronous active-high reset
//   ihit, dhit            fetch / data access complete this cycle
//   id_rs, id_rt          register fields of the instruction in ID
//   id_uses_rt            ID instruction reads rt
//   ex_dREN, ex_wsel      load flag and destination of the instruction in EX
//   ex_jumpFlush          taken control transfer resolved in EX
//   mem_dREN, mem_dWEN    load / store in MEM
//   wb_halt               halt instruction in WB
//   pc_en .. memwb_en     latch enables; ifid_flush / idex_flush clear to nop
//   halted                sticky halt indication
//   stall_cycles          stall counter (optional)
//   flush_events          taken-transfer flush counter (optional)
//
// Configuration:
//   HAZARD_PERF_CNT_EN    when defined, stall_cycles / flush_events are live
//                         counters; otherwise both ports are tied to 0.
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_dREN,
  input  logic [REG_W-1:0] ex_wsel,
  input  logic             ex_jumpFlush,
  input  logic             mem_dREN,
  input  logic             mem_dWEN,
  input  logic             wb_halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, HALTED} state_e;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_flush;
    logic exmem_en;
    logic memwb_en;
    logic halted;
  } ctrl_t;

  state_e state_q, state_d;
  ctrl_t  ctrl;

  logic dmem_busy;
  logic advance;
  logic lu;
  logic stall_ev;
  logic flush_ev;

  assign dmem_busy = (mem_dREN | mem_dWEN) & ~dhit;
  assign advance   = ihit & ~dmem_busy;
  // r0 is hard-wired zero, so a load targeting it never creates a dependency.
  assign lu = ex_dREN & (ex_wsel != '0) &
              ((ex_wsel == id_rs) | (id_uses_rt & (ex_wsel == id_rt)));

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    ctrl     = '0;
    stall_ev = 1'b0;
    flush_ev = 1'b0;
    case (state_q)
      HALTED: ctrl.halted = 1'b1;
      RUN, MEM_WAIT: begin
        // A lu bubble counts as a stall even though the pipe partly advances.
        stall_ev = ~advance | (advance & lu & ~ex_jumpFlush);
        if (state_q == MEM_WAIT && !dhit) begin
          // Waiting for the data access: hold everything.
        end else if (dmem_busy) begin
          state_d = MEM_WAIT;
        end else begin
          state_d = RUN;
          if (advance) begin
            if (ex_jumpFlush) begin
              ctrl     = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b1,
                           idex_en: 1'b1, idex_flush: 1'b1, exmem_en: 1'b1,
                           memwb_en: 1'b1, halted: 1'b0};
              flush_ev = 1'b1;
            end else if (lu) begin
              // Hold PC and IF/ID, push one bubble into EX.
              ctrl     = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0,
                           idex_en: 1'b1, idex_flush: 1'b1, exmem_en: 1'b1,
                           memwb_en: 1'b1, halted: 1'b0};
            end else begin
              ctrl     = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0,
                           idex_en: 1'b1, idex_flush: 1'b0, exmem_en: 1'b1,
                           memwb_en: 1'b1, halted: 1'b0};
            end
          end
        end
        if (wb_halt) state_d = HALTED;
      end
      default: state_d = RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= RUN;
    else     state_q <= state_d;
  end

  // Outputs are forced low during reset independent of the decoded state.
  assign pc_en      = ~RST & ctrl.pc_en;
  assign ifid_en    = ~RST & ctrl.ifid_en;
  assign ifid_flush = ~RST & ctrl.ifid_flush;
  assign idex_en    = ~RST & ctrl.idex_en;
  assign idex_flush = ~RST & ctrl.idex_flush;
  assign exmem_en   = ~RST & ctrl.exmem_en;
  assign memwb_en   = ~RST & ctrl.memwb_en;
  assign halted     = ~RST & ctrl.halted;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  // Counters wrap naturally; the events are already zero in HALTED.
  assign stall_d = stall_q + CNT_W'(stall_ev);
  assign flush_d = flush_q + CNT_W'(flush_ev);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_events = flush_q;
`else
  logic unused_ev;
  assign unused_ev    = stall_ev ^ flush_ev;
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Self-checking bench for hazard_ctrl. Each step drives inputs on the falling
// edge, pushes the expected control vector onto a queue, and pops/compares it
// against the DUT shortly afterwards. Counter expectations are tracked
// alongside and only become non-zero when HAZARD_PERF_CNT_EN is defined.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

  localparam int REG_W = 5;
  localparam int CNT_W = 32;

  // Expected vector: {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
  //                   exmem_en, memwb_en, halted}
  localparam logic [7:0] V_ZERO   = 8'b0000_0000;
  localparam logic [7:0] V_RUN    = 8'b1101_0110;
  localparam logic [7:0] V_FLUSH  = 8'b1111_1110;
  localparam logic [7:0] V_BUBBLE = 8'b0001_1110;
  localparam logic [7:0] V_HALT   = 8'b0000_0001;

  logic             CLK = 1'b0;
  logic             RST;
  logic             ihit, dhit;
  logic [REG_W-1:0] id_rs, id_rt;
  logic             id_uses_rt;
  logic             ex_dREN;
  logic [REG_W-1:0] ex_wsel;
  logic             ex_jumpFlush;
  logic             mem_dREN, mem_dWEN;
  logic             wb_halt;
  logic             pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
  logic             exmem_en, memwb_en, halted;
  logic [CNT_W-1:0] stall_cycles, flush_events;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] exp_q[$];
  string      tag_q[$];
  logic [CNT_W-1:0] exp_stall = '0;
  logic [CNT_W-1:0] exp_flush = '0;

  always #5 CLK = ~CLK;

  hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_dREN(ex_dREN), .ex_wsel(ex_wsel), .ex_jumpFlush(ex_jumpFlush),
    .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .wb_halt(wb_halt),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_en(idex_en), .idex_flush(idex_flush), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .halted(halted),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  task automatic idle_inputs();
    ihit = 1'b1; dhit = 1'b0; id_rs = '0; id_rt = '0; id_uses_rt = 1'b0;
    ex_dREN = 1'b0; ex_wsel = '0; ex_jumpFlush = 1'b0;
    mem_dREN = 1'b0; mem_dWEN = 1'b0; wb_halt = 1'b0;
  endtask

  // Inputs are already applied (at a falling edge). Push the expectation,
  // let the combinational outputs settle, pop and compare, then advance to
  // the next falling edge. Counter increments land on the rising edge.
  task automatic step(input logic [7:0] exp_v, input string tag,
                      input int stall_inc, input int flush_inc);
    logic [7:0] got, want;
    string      t;
    exp_q.push_back(exp_v);
    tag_q.push_back(tag);
    #1;
    got  = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
            exmem_en, memwb_en, halted};
    want = exp_q.pop_front();
    t    = tag_q.pop_front();
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s ctrl: got %b want %b", t, got, want);
    end
    n_cmp++;
    if (stall_cycles !== exp_stall) begin
      n_bad++;
      $display("FAIL %s stall_cycles: got %0d want %0d", t, stall_cycles, exp_stall);
    end
    n_cmp++;
    if (flush_events !== exp_flush) begin
      n_bad++;
      $display("FAIL %s flush_events: got %0d want %0d", t, flush_events, exp_flush);
    end
`ifdef HAZARD_PERF_CNT_EN
    if (RST == 1'b0) begin
      exp_stall += CNT_W'(stall_inc);
      exp_flush += CNT_W'(flush_inc);
    end
`else
    if (stall_inc < 0 || flush_inc < 0) $display("negative increment in %s", tag);
`endif
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    exp_stall = '0;
    exp_flush = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    do_reset();
    step(V_ZERO, "reset_hold", 0, 0);
    step(V_ZERO, "reset_hold2", 0, 0);
    RST = 1'b0;
    for (int i = 0; i < 3; i++) step(V_RUN, "free_run", 0, 0);
    ihit = 1'b0;
    step(V_ZERO, "fetch_miss", 1, 0);
    ihit = 1'b1;
    step(V_RUN, "fetch_hit", 0, 0);
  endtask

  task automatic test_load_use();
    idle_inputs();
    ex_dREN = 1'b1; ex_wsel = 5'd8; id_rs = 5'd8;
    step(V_BUBBLE, "lu_rs_bubble", 1, 0);
    ex_dREN = 1'b0;
    step(V_RUN, "lu_after_bubble", 0, 0);
    ex_dREN = 1'b1; id_rs = 5'd3; id_rt = 5'd8; id_uses_rt = 1'b0;
    step(V_RUN, "lu_rt_unused", 0, 0);
    id_uses_rt = 1'b1;
    step(V_BUBBLE, "lu_rt_used", 1, 0);
    ex_dREN = 1'b0;
    step(V_RUN, "lu_rt_after", 0, 0);
    ex_dREN = 1'b1; id_rs = 5'd8; ihit = 1'b0;
    step(V_ZERO, "lu_no_advance", 1, 0);
  endtask

  task automatic test_mem_wait();
    idle_inputs();
    mem_dREN = 1'b1;
    for (int i = 0; i < 3; i++) step(V_ZERO, "dmem_wait", 1, 0);
    dhit = 1'b1;
    step(V_RUN, "dmem_hit", 0, 0);
    mem_dREN = 1'b0; dhit = 1'b0;
    step(V_RUN, "dmem_back_run", 0, 0);
    mem_dWEN = 1'b1;
    step(V_ZERO, "dstore_wait", 1, 0);
    dhit = 1'b1; ihit = 1'b0;
    step(V_ZERO, "dstore_hit_no_ihit", 1, 0);
    mem_dWEN = 1'b0; dhit = 1'b0; ihit = 1'b1;
    step(V_RUN, "dstore_back_run", 0, 0);
  endtask

  task automatic test_jump();
    idle_inputs();
    ex_jumpFlush = 1'b1; ihit = 1'b0;
    step(V_ZERO, "jmp_miss0", 1, 0);
    step(V_ZERO, "jmp_miss1", 1, 0);
    ihit = 1'b1;
    step(V_FLUSH, "jmp_flush", 0, 1);
    ex_jumpFlush = 1'b0;
    step(V_RUN, "jmp_after", 0, 0);
    ex_jumpFlush = 1'b1; ex_dREN = 1'b1; ex_wsel = 5'd8; id_rs = 5'd8;
    step(V_FLUSH, "jmp_over_lu", 0, 1);
    ex_jumpFlush = 1'b0; ex_dREN = 1'b0;
    mem_dREN = 1'b1;
    step(V_ZERO, "jmp_memwait_entry", 1, 0);
    dhit = 1'b1; ex_jumpFlush = 1'b1;
    step(V_FLUSH, "jmp_memwait_exit", 0, 1);
    idle_inputs();
    step(V_RUN, "jmp_done", 0, 0);
  endtask

  task automatic test_zero_reg();
    idle_inputs();
    ex_dREN = 1'b1; ex_wsel = '0; id_rs = '0; id_rt = '0; id_uses_rt = 1'b1;
    step(V_RUN, "zero_reg_hit", 0, 0);
    ihit = 1'b0;
    step(V_ZERO, "zero_reg_miss", 1, 0);
    ihit = 1'b1;
    step(V_RUN, "zero_reg_hit2", 0, 0);
  endtask

  task automatic test_reset_mid_wait();
    idle_inputs();
    mem_dREN = 1'b1;
    step(V_ZERO, "rst_mw_enter", 1, 0);
    step(V_ZERO, "rst_mw_wait", 1, 0);
    do_reset();
    step(V_ZERO, "rst_mw_reset", 0, 0);
    RST = 1'b0; mem_dREN = 1'b0;
    step(V_RUN, "rst_mw_run", 0, 0);
  endtask

  task automatic test_halt();
    idle_inputs();
    wb_halt = 1'b1;
    step(V_RUN, "halt_cycle", 0, 0);
    wb_halt = 1'b0; dhit = 1'b1;
    for (int i = 0; i < 4; i++) step(V_HALT, "halted_hold", 0, 0);
    ex_jumpFlush = 1'b1; ex_dREN = 1'b1; ex_wsel = 5'd4; id_rs = 5'd4;
    step(V_HALT, "halted_hazards", 0, 0);
    do_reset();
    step(V_ZERO, "halt_reset", 0, 0);
    idle_inputs();
    RST = 1'b0;
    step(V_RUN, "halt_exit_run", 0, 0);
  endtask

  initial begin
    RST = 1'b1;
    idle_inputs();
    @(negedge CLK);
    test_reset();
    test_load_use();
    test_mem_wait();
    test_jump();
    test_zero_reg();
    test_reset_mid_wait();
    test_halt();
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
